// File: rtl/prime_candidate_tester.sv
// Trial-division primality tester for a free-running candidate sequence, one test per pacing tick.
// Optional macro PRIME_COUNT_EN adds a saturating count of primes handed downstream.
module prime_candidate_tester #(
  parameter int WIDTH = 8,
  parameter int START = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_value,
  output logic             result_prime,
  output logic             overrun
`ifdef PRIME_COUNT_EN
  ,
  output logic [WIDTH-1:0] prime_count
`endif
);

  // Output handshake: a result transfers on any rising edge where result_valid && result_ready;
  // result_valid never drops and result_value/result_prime never change before that edge.
  typedef enum logic [2:0] {IDLE, LOAD, SUB, CHECK, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   next_cand;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic               verdict;
  logic [2*WIDTH-1:0] dplus;
  logic [2*WIDTH-1:0] dplus_sq;
  logic               small_cand;
  logic               rem_ge;
  logic               rem_zero;
  logic               sq_exceeds;
  logic               transfer;

  assign small_cand = next_cand < WIDTH'(4);
  assign rem_ge     = rem >= divisor;
  assign rem_zero   = rem == '0;
  // Square of the next divisor at double width so it can never wrap.
  assign dplus      = {{WIDTH{1'b0}}, divisor} + (2*WIDTH)'(1);
  assign dplus_sq   = dplus * dplus;
  assign sq_exceeds = dplus_sq > {{WIDTH{1'b0}}, cand};
  assign transfer   = (state == DONE) && result_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    busy         = (state != IDLE);
    result_valid = (state == DONE);
    result_value = (state == DONE) ? cand : '0;
    result_prime = (state == DONE) && verdict;
    case (state)
      IDLE:  if (tick) state_next = LOAD;
      LOAD:  state_next = small_cand ? DONE : SUB;
      SUB:   if (!rem_ge) state_next = CHECK;
      CHECK: state_next = (rem_zero || sq_exceeds) ? DONE : SUB;
      DONE:  if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_cand <= WIDTH'(START);
      cand      <= '0;
      divisor   <= '0;
      rem       <= '0;
      verdict   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        LOAD: begin
          cand    <= next_cand;
          divisor <= WIDTH'(2);
          rem     <= next_cand;
          verdict <= small_cand;
        end
        SUB: if (rem_ge) rem <= rem - divisor;
        CHECK: begin
          if (rem_zero) begin
            verdict <= 1'b0;
          end else if (sq_exceeds) begin
            verdict <= 1'b1;
          end else begin
            divisor <= divisor + WIDTH'(1);
            rem     <= cand;
          end
        end
        // 0 and 1 are never candidates, so the sequence wraps from all-ones back to 2.
        DONE: if (result_ready) next_cand <= (next_cand == '1) ? WIDTH'(2) : next_cand + WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef PRIME_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prime_count <= '0;
    else if (transfer && verdict && prime_count != '1) prime_count <= prime_count + WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_prime_candidate_tester.sv
// Directed bench for prime_candidate_tester: an 8-bit instance tracked by a scoreboard and a 4-bit instance for wrap/reset cases.
module tb_prime_candidate_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst4, tick8, tick4, ready8, ready4;
  logic       busy8, valid8, prime8, ovr8;
  logic [7:0] val8;
  logic       busy4, valid4, prime4, ovr4;
  logic [3:0] val4;
`ifdef PRIME_COUNT_EN
  logic [7:0] pc8;
  logic [3:0] pc4;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int model_cand8 = 2;
  int model_cand4 = 2;

  prime_candidate_tester #(.WIDTH(8), .START(2)) dut8 (
    .clk(clk), .reset(rst), .tick(tick8), .result_ready(ready8),
    .busy(busy8), .result_valid(valid8), .result_value(val8),
    .result_prime(prime8), .overrun(ovr8)
`ifdef PRIME_COUNT_EN
    , .prime_count(pc8)
`endif
  );

  prime_candidate_tester #(.WIDTH(4), .START(2)) dut4 (
    .clk(clk), .reset(rst4), .tick(tick4), .result_ready(ready4),
    .busy(busy4), .result_valid(valid4), .result_value(val4),
    .result_prime(prime4), .overrun(ovr4)
`ifdef PRIME_COUNT_EN
    , .prime_count(pc4)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic from the rules, not from the state machine.
  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int lat_model(input int n);
    int sum;
    int d;
    bit go;
    if (n < 4) return 2;
    sum = 0;
    d = 2;
    go = 1'b1;
    while (go) begin
      sum += n / d + 2;
      if (n % d == 0 || (d + 1) * (d + 1) > n) go = 1'b0;
      else d++;
    end
    return 2 + sum;
  endfunction

  function automatic int wrap_next(input int c, input int w);
    return (c == (1 << w) - 1) ? 2 : c + 1;
  endfunction

  function automatic logic cur_valid(input bit which);
    return which ? valid4 : valid8;
  endfunction

  function automatic logic cur_busy(input bit which);
    return which ? busy4 : busy8;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the queue head.
  always @(negedge clk) begin
    if (!rst && valid8) begin
      check("queue_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("mon_value", val8, exp_q[0]);
        check("mon_prime", prime8, is_prime(exp_q[0]));
        check("mon_busy", busy8, 1);
        if (ready8) void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_ready(input bit which, input logic v);
    if (which) ready4 = v;
    else       ready8 = v;
  endtask

  task automatic set_tick(input bit which, input logic v);
    if (which) tick4 = v;
    else       tick8 = v;
  endtask

  task automatic pulse_tick(input bit which);
    @(posedge clk); #1;
    set_tick(which, 1'b1);
    @(posedge clk); #1;
    set_tick(which, 1'b0);
  endtask

  task automatic wait_valid(input bit which, output int edges);
    edges = 1;
    while (!cur_valid(which) && edges < 4000) begin
      @(posedge clk); #1;
      edges++;
    end
    check("valid_arrives", cur_valid(which), 1);
  endtask

  task automatic run(input bit which, input int exp_val, input bit exp_prime, input int stall);
    int edges;
    int mval;
    mval = which ? model_cand4 : model_cand8;
    if (!which) exp_q.push_back(8'(mval));
    set_ready(which, stall == 0);
    pulse_tick(which);
    wait_valid(which, edges);
    check("latency", edges, lat_model(mval));
    check("value", which ? int'(val4) : int'(val8), exp_val);
    check("prime", which ? prime4 : prime8, exp_prime);
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      check("stall_still_valid", cur_valid(which), 1);
      set_ready(which, 1'b1);
    end
    @(posedge clk); #1;
    check("post_valid", cur_valid(which), 0);
    check("post_busy", cur_busy(which), 0);
    if (which) model_cand4 = wrap_next(model_cand4, 4);
    else       model_cand8 = wrap_next(model_cand8, 8);
  endtask

  initial begin
    bit flags [12];
    int edges;
    int extra;
    flags = '{1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1};
    rst = 1'b1; rst4 = 1'b1;
    tick8 = 1'b0; tick4 = 1'b0;
    ready8 = 1'b1; ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst4 = 1'b0;

    // Idle after reset: everything stays low.
    repeat (20) begin
      @(posedge clk); #1;
      check("idle_flags", {busy8, valid8, prime8, ovr8}, 0);
      check("idle_value", val8, 0);
    end
`ifdef PRIME_COUNT_EN
    check("count_reset", pc8, 0);
`endif

    run(1'b0, 2, 1'b1, 0);
    run(1'b0, 3, 1'b1, 0);
    run(1'b0, 4, 1'b0, 0);
    for (int n = 5; n <= 13; n++) run(1'b0, n, flags[n-2], (n == 9) ? 30 : 0);
`ifdef PRIME_COUNT_EN
    check("count_after_13", pc8, 6);
`endif

    // Second tick during a test is dropped and latches overrun.
    exp_q.push_back(8'(model_cand8));
    pulse_tick(1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("overrun_before", ovr8, 0);
    pulse_tick(1'b0);
    check("overrun_set", ovr8, 1);
    wait_valid(1'b0, edges);
    check("ovr_value", val8, 14);
    check("ovr_prime", prime8, 0);
    @(posedge clk); #1;
    model_cand8 = wrap_next(model_cand8, 8);
    extra = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (valid8 || busy8) extra++;
    end
    check("single_result", extra, 0);
    check("overrun_sticky", ovr8, 1);
    run(1'b0, 15, 1'b0, 0);

    // Tick on the transfer cycle is dropped.
    exp_q.push_back(8'(model_cand8));
    ready8 = 1'b0;
    pulse_tick(1'b0);
    wait_valid(1'b0, edges);
    check("xfer_tick_value", val8, 16);
    tick8 = 1'b1;
    ready8 = 1'b1;
    @(posedge clk); #1;
    tick8 = 1'b0;
    check("xfer_tick_valid", valid8, 0);
    check("xfer_tick_busy", busy8, 0);
    model_cand8 = wrap_next(model_cand8, 8);
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy8) extra++;
    end
    check("xfer_tick_dropped", extra, 0);
    run(1'b0, 17, 1'b1, 0);
    check("queue_drained", exp_q.size(), 0);
`ifdef PRIME_COUNT_EN
    check("count_final8", pc8, 7);
`endif

    // 4-bit instance: walk to the top, wrap, then reset mid-test.
    for (int n = 2; n <= 14; n++) run(1'b1, n, is_prime(n), 0);
    run(1'b1, 15, 1'b0, 0);
    run(1'b1, 2, 1'b1, 0);
    for (int n = 3; n <= 12; n++) run(1'b1, n, is_prime(n), 0);
    check("model4_at_13", model_cand4, 13);
    pulse_tick(1'b1);
    repeat (2) begin @(posedge clk); #1; end
    check("w4_busy_in_sub", busy4, 1);
    #2;
    rst4 = 1'b1;
    #1;
    check("w4_async_flags", {busy4, valid4, prime4, ovr4}, 0);
    check("w4_async_value", val4, 0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    model_cand4 = 2;
    run(1'b1, 2, 1'b1, 0);
    check("w4_overrun_clear", ovr4, 0);
`ifdef PRIME_COUNT_EN
    check("count_final4", pc4, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
